// File: rtl/ahb_rif_pkg.sv
// Shared types and helpers for the AHB-Lite to RIF bridge.
// size_mask returns a right-aligned byte mask of 2^size bytes, clipped to byte_count.
package ahb_rif_pkg;

   typedef enum logic [1:0] {
      TransIdle   = 2'b00,
      TransBusy   = 2'b01,
      TransNonseq = 2'b10,
      TransSeq    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      StIdle,
      StAccess,
      StRdone,
      StErr1,
      StErr2
   } bridge_state_t;

   localparam int unsigned MaxBytes = 128;

   function automatic logic [MaxBytes-1:0] size_mask(input logic [2:0] size,
                                                     input int unsigned byte_count);
      logic [MaxBytes-1:0] m;
      m = '0;
      for (int i = 0; i < int'(MaxBytes); i++) begin
         if ((i < (1 << size)) && (i < int'(byte_count))) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/ahb_rif_strb_gen.sv
// Combinational byte-strobe generator with size and alignment checks.
module ahb_rif_strb_gen
   import ahb_rif_pkg::*;
#(
   parameter int unsigned BYTE_COUNT = 4,
   parameter int unsigned OFF_W      = 2
) (
   input  logic [OFF_W-1:0]      addr_lo_i,
   input  logic [2:0]            size_i,
   output logic [BYTE_COUNT-1:0] strb_o,
   output logic                  align_err_o,
   output logic                  size_err_o
);

   localparam int unsigned Log2Bc = (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 0;

   logic [MaxBytes-1:0]   mask_full;
   logic [BYTE_COUNT-1:0] mask;
   logic [OFF_W-1:0]      off;
   logic                  unused_mask;

   always_comb begin
      mask_full   = size_mask(size_i, BYTE_COUNT);
      mask        = mask_full[BYTE_COUNT-1:0];
      // A single-byte bus has no offset bits; the port bit is ignored.
      off         = (BYTE_COUNT > 1) ? addr_lo_i : '0;
      strb_o      = mask << off;
      size_err_o  = 32'(size_i) > Log2Bc;
      align_err_o = 1'b0;
      for (int i = 0; i < int'(OFF_W); i++) begin
         if ((i < int'(size_i)) && off[i]) align_err_o = 1'b1;
      end
   end

   assign unused_mask = ^mask_full;

endmodule

// File: rtl/ahb_lite_rif_bridge.sv
// AHB-Lite slave to RIF bridge with wait states, byte strobes, pre-checks,
// optional registered read data, RIF timeout and a two-cycle ERROR response.
module ahb_lite_rif_bridge
   import ahb_rif_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SEC_TRANS  = 0,
   parameter int unsigned RD_REG     = 0,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                    HCLK,
   input  logic                    HRESETn,
   input  logic [ADDR_WIDTH-1:0]   HADDR,
   input  logic                    HSEL,
   input  logic                    HNONSEC,
   input  logic [2:0]              HSIZE,
   input  logic [1:0]              HTRANS,
   input  logic                    HWRITE,
   input  logic                    HREADYIN,
   input  logic [2:0]              HBURST,
   input  logic [DATA_WIDTH-1:0]   HWDATA,
   output logic [DATA_WIDTH-1:0]   HRDATA,
   output logic                    HREADYOUT,
   output logic                    HRESP,
   output logic [ADDR_WIDTH-1:0]   rif_addr,
   output logic                    rif_wr_req,
   output logic                    rif_rd_req,
   output logic [DATA_WIDTH/8-1:0] rif_wstrb,
   output logic [DATA_WIDTH-1:0]   rif_wdata,
   input  logic [DATA_WIDTH-1:0]   rif_rdata,
   input  logic                    rif_ready,
   input  logic                    rif_err
);

   localparam int unsigned ByteCount = DATA_WIDTH / 8;
   localparam int unsigned OffW      = (ByteCount > 1) ? $clog2(ByteCount) : 1;
   localparam int unsigned CntW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64 ||
         DATA_WIDTH == 128 || DATA_WIDTH == 256 || DATA_WIDTH == 512 ||
         DATA_WIDTH == 1024)) begin : g_bad_width
      $fatal(1, "ahb_lite_rif_bridge: illegal DATA_WIDTH %0d", DATA_WIDTH);
   end

   bridge_state_t          state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [ByteCount-1:0]   strb_q, strb_d;
   logic                   write_q, write_d;
   logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;

   htrans_t                trans;
   logic                   accept, pre_err, can_accept, rd_reg_read;
   logic                   align_err, size_err;
   logic [ByteCount-1:0]   strb_new;
   logic [DATA_WIDTH-1:0]  strb_bits, rdata_masked;
   logic                   unused_burst;

   assign trans   = htrans_t'(HTRANS);
   assign accept  = HSEL & HREADYIN & ((trans == TransNonseq) | (trans == TransSeq));
   assign pre_err = size_err | align_err | ((SEC_TRANS != 0) & HNONSEC);
   assign unused_burst = ^HBURST;

   ahb_rif_strb_gen #(
      .BYTE_COUNT (ByteCount),
      .OFF_W      (OffW)
   ) u_strb_gen (
      .addr_lo_i   (HADDR[OffW-1:0]),
      .size_i      (HSIZE),
      .strb_o      (strb_new),
      .align_err_o (align_err),
      .size_err_o  (size_err)
   );

   always_comb begin
      for (int b = 0; b < int'(ByteCount); b++) strb_bits[b*8 +: 8] = {8{strb_q[b]}};
   end

   assign rdata_masked = rif_rdata & strb_bits;
   assign rd_reg_read  = (RD_REG != 0) && !write_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      strb_d     = strb_q;
      write_d    = write_q;
      rdata_d    = rdata_q;
      can_accept = 1'b0;
      unique case (state_q)
         StIdle, StRdone, StErr2: can_accept = 1'b1;
         StAccess: begin
            if (rif_ready && !rif_err) begin
               if (!write_q) rdata_d = rdata_masked;
               if (rd_reg_read) state_d = StRdone;
               else can_accept = 1'b1;
            end else if (rif_ready) begin
               state_d = StErr1;
            end else if ((TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT))) begin
               state_d = StErr1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StErr1:  state_d = StErr2;
         default: state_d = StIdle;
      endcase
      // Completion cycles double as the next address phase.
      if (can_accept) begin
         if (accept) begin
            addr_d  = HADDR;
            strb_d  = strb_new;
            write_d = HWRITE;
            cnt_d   = '0;
            state_d = pre_err ? StErr1 : StAccess;
         end else begin
            state_d = StIdle;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         strb_q  <= '0;
         write_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         strb_q  <= strb_d;
         write_q <= write_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      HREADYOUT  = 1'b1;
      HRESP      = 1'b0;
      HRDATA     = rdata_q;
      rif_wr_req = 1'b0;
      rif_rd_req = 1'b0;
      unique case (state_q)
         StAccess: begin
            rif_wr_req = write_q;
            rif_rd_req = !write_q;
            HREADYOUT  = rif_ready & ~rif_err & ~rd_reg_read;
            if (!write_q && (RD_REG == 0)) HRDATA = rdata_masked;
         end
         StErr1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
         end
         StErr2:  HRESP = 1'b1;
         default: ;
      endcase
   end

   assign rif_addr  = addr_q;
   assign rif_wstrb = strb_q;
   assign rif_wdata = HWDATA & strb_bits;

endmodule

// File: tb/tb_ahb_lite_rif_bridge.sv
// Bench for ahb_lite_rif_bridge: dut0 (RD_REG=0, SEC_TRANS=0, TIMEOUT=4) and
// dut1 (RD_REG=1, SEC_TRANS=1, TIMEOUT=16) share stimulus, one selected at a time.
module tb_ahb_lite_rif_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] haddr;
   logic        hsel, hnonsec, hwrite;
   logic [2:0]  hsize, hburst;
   logic [1:0]  htrans;
   logic [31:0] hwdata, rif_rdata;
   logic        rif_ready, rif_err;
   logic        sel;

   logic [31:0] hrdata_0, hrdata_1, wdata_0, wdata_1;
   logic        hro_0, hro_1, hresp_0, hresp_1;
   logic        wr_0, wr_1, rd_0, rd_1;
   logic [11:0] addr_0, addr_1;
   logic [3:0]  strb_0, strb_1;

   logic [31:0] hrdata, rwdata;
   logic        hreadyout, hresp, wr_req, rd_req;
   logic [11:0] raddr;
   logic [3:0]  rstrb;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ahb_lite_rif_bridge #(
      .ADDR_WIDTH(12), .DATA_WIDTH(32), .SEC_TRANS(0), .RD_REG(0), .TIMEOUT(4)
   ) dut0 (
      .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HSEL(hsel & ~sel), .HNONSEC(hnonsec),
      .HSIZE(hsize), .HTRANS(htrans), .HWRITE(hwrite), .HREADYIN(hro_0), .HBURST(hburst),
      .HWDATA(hwdata), .HRDATA(hrdata_0), .HREADYOUT(hro_0), .HRESP(hresp_0),
      .rif_addr(addr_0), .rif_wr_req(wr_0), .rif_rd_req(rd_0), .rif_wstrb(strb_0),
      .rif_wdata(wdata_0), .rif_rdata(rif_rdata), .rif_ready(rif_ready), .rif_err(rif_err)
   );

   ahb_lite_rif_bridge #(
      .ADDR_WIDTH(12), .DATA_WIDTH(32), .SEC_TRANS(1), .RD_REG(1), .TIMEOUT(16)
   ) dut1 (
      .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HSEL(hsel & sel), .HNONSEC(hnonsec),
      .HSIZE(hsize), .HTRANS(htrans), .HWRITE(hwrite), .HREADYIN(hro_1), .HBURST(hburst),
      .HWDATA(hwdata), .HRDATA(hrdata_1), .HREADYOUT(hro_1), .HRESP(hresp_1),
      .rif_addr(addr_1), .rif_wr_req(wr_1), .rif_rd_req(rd_1), .rif_wstrb(strb_1),
      .rif_wdata(wdata_1), .rif_rdata(rif_rdata), .rif_ready(rif_ready), .rif_err(rif_err)
   );

   assign hrdata    = sel ? hrdata_1 : hrdata_0;
   assign hreadyout = sel ? hro_1    : hro_0;
   assign hresp     = sel ? hresp_1  : hresp_0;
   assign wr_req    = sel ? wr_1     : wr_0;
   assign rd_req    = sel ? rd_1     : rd_0;
   assign raddr     = sel ? addr_1   : addr_0;
   assign rstrb     = sel ? strb_1   : strb_0;
   assign rwdata    = sel ? wdata_1  : wdata_0;

   function automatic logic [31:0] bytes_to_bits(input logic [3:0] s);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = 8'hFF;
      return m;
   endfunction

   // One transfer through the selected bridge; the expected behaviour comes from
   // counting cycles with the rules of the bus protocol, not from any state machine.
   task automatic do_xfer(input logic s, input logic [11:0] a, input logic [2:0] sz,
                          input logic wr, input logic ns, input logic [31:0] wd,
                          input logic [31:0] rd, input int waits, input logic err,
                          input string name);
      int          nb, ai, sh, tmo, exp_access, exp_cycles, k, reqs, resp_cnt;
      logic        rd_reg, sec, pre, exp_err, done, seen, cap_wr, fin_resp;
      logic [3:0]  exp_strb, cap_strb;
      logic [11:0] cap_addr;
      logic [31:0] cap_wdata, fin_rdata, exp_mask;
      rd_reg = s;
      sec    = s;
      tmo    = s ? 16 : 4;
      nb     = 1 << sz;
      ai     = int'(a);
      pre    = (sz > 3'd2) || ((ai % nb) != 0) || (sec && ns);
      sh     = ((1 << nb) - 1) << (ai % 4);
      exp_strb = sh[3:0];
      exp_mask = bytes_to_bits(exp_strb);
      if (pre) begin
         exp_access = 0;  exp_cycles = 2;  exp_err = 1'b1;
      end else if (waits > tmo) begin
         exp_access = tmo + 1;  exp_cycles = tmo + 3;  exp_err = 1'b1;
      end else if (err) begin
         exp_access = waits + 1;  exp_cycles = waits + 3;  exp_err = 1'b1;
      end else begin
         exp_access = waits + 1;
         exp_cycles = waits + 1 + ((rd_reg && !wr) ? 1 : 0);
         exp_err    = 1'b0;
      end

      @(posedge clk); #1;
      sel = s; hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = sz; hwrite = wr; hnonsec = ns;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00; hwdata = wd; rif_rdata = rd;
      k = 0; done = 1'b0; seen = 1'b0; reqs = 0; resp_cnt = 0;
      cap_wr = 1'b0; cap_addr = '0; cap_strb = '0; cap_wdata = '0;
      fin_resp = 1'b0; fin_rdata = '0;
      while (!done && k < 40) begin
         rif_ready = (k >= waits);
         rif_err   = err && (k >= waits);
         @(negedge clk);
         if (wr_req || rd_req) begin
            if (!seen) begin
               seen = 1'b1; cap_wr = wr_req; cap_addr = raddr; cap_strb = rstrb;
               cap_wdata = rwdata;
            end
            reqs++;
         end
         if (hresp) resp_cnt++;
         if (hreadyout) begin
            done = 1'b1; fin_resp = hresp; fin_rdata = hrdata;
         end
         k++;
         @(posedge clk); #1;
      end
      rif_ready = 1'b0; rif_err = 1'b0;

      n_checks++;
      if (!done || k !== exp_cycles) begin
         n_fail++;
         $display("FAIL %s data_phase_cycles: got %0d (done=%0b) expected %0d",
                  name, k, done, exp_cycles);
      end
      n_checks++;
      if (fin_resp !== exp_err) begin
         n_fail++;
         $display("FAIL %s final_hresp: got %0b expected %0b", name, fin_resp, exp_err);
      end
      n_checks++;
      if (resp_cnt !== (exp_err ? 2 : 0)) begin
         n_fail++;
         $display("FAIL %s error_cycles: got %0d expected %0d", name, resp_cnt,
                  exp_err ? 2 : 0);
      end
      n_checks++;
      if (reqs !== exp_access) begin
         n_fail++;
         $display("FAIL %s request_cycles: got %0d expected %0d", name, reqs, exp_access);
      end
      if (exp_access > 0) begin
         n_checks++;
         if (cap_wr !== wr || cap_addr !== a || cap_strb !== exp_strb) begin
            n_fail++;
            $display("FAIL %s request: got wr=%0b addr=%h strb=%b expected wr=%0b addr=%h strb=%b",
                     name, cap_wr, cap_addr, cap_strb, wr, a, exp_strb);
         end
         if (wr) begin
            n_checks++;
            if (cap_wdata !== (wd & exp_mask)) begin
               n_fail++;
               $display("FAIL %s rif_wdata: got %h expected %h", name, cap_wdata,
                        wd & exp_mask);
            end
         end
      end
      if (!exp_err && !wr) begin
         n_checks++;
         if (fin_rdata !== (rd & exp_mask)) begin
            n_fail++;
            $display("FAIL %s hrdata: got %h expected %h", name, fin_rdata, rd & exp_mask);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      hwdata = 32'hDEADBEEF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (hro_0 !== 1'b1 || hresp_0 !== 1'b0 || hrdata_0 !== 32'h0 || wr_0 !== 1'b0 ||
          rd_0 !== 1'b0 || addr_0 !== 12'h0 || strb_0 !== 4'h0 || wdata_0 !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_dut0: got rdy=%0b resp=%0b rdata=%h wr=%0b rd=%0b addr=%h strb=%b wdata=%h expected 1 0 0 0 0 0 0 0",
                  hro_0, hresp_0, hrdata_0, wr_0, rd_0, addr_0, strb_0, wdata_0);
      end
      n_checks++;
      if (hro_1 !== 1'b1 || hresp_1 !== 1'b0 || hrdata_1 !== 32'h0 || wr_1 !== 1'b0 ||
          rd_1 !== 1'b0 || addr_1 !== 12'h0 || strb_1 !== 4'h0 || wdata_1 !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_dut1: got rdy=%0b resp=%0b rdata=%h wr=%0b rd=%0b addr=%h strb=%b wdata=%h expected 1 0 0 0 0 0 0 0",
                  hro_1, hresp_1, hrdata_1, wr_1, rd_1, addr_1, strb_1, wdata_1);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_idle_busy();
      @(posedge clk); #1;
      sel = 1'b0; hsel = 1'b1; htrans = 2'b01; haddr = 12'h040; hsize = 3'd2; hwrite = 1'b1;
      @(posedge clk); #1;
      htrans = 2'b00;
      @(negedge clk);
      n_checks++;
      if (hreadyout !== 1'b1 || hresp !== 1'b0 || wr_req !== 1'b0 || rd_req !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_idle: got rdy=%0b resp=%0b wr=%0b rd=%0b expected 1 0 0 0",
                  hreadyout, hresp, wr_req, rd_req);
      end
      @(posedge clk); #1;
      hsel = 1'b0;
   endtask

   task automatic test_directed();
      do_xfer(1'b0, 12'h006, 3'd1, 1'b1, 1'b0, 32'hABCD1234, 32'h0, 0, 1'b0, "half_write");
      do_xfer(1'b1, 12'h010, 3'd2, 1'b0, 1'b0, 32'h0, 32'h5A5A5A5A, 3, 1'b0, "rdreg_read");
      do_xfer(1'b0, 12'h002, 3'd2, 1'b0, 1'b0, 32'h0, 32'h11223344, 0, 1'b0, "unaligned");
      do_xfer(1'b1, 12'h010, 3'd2, 1'b0, 1'b1, 32'h0, 32'h11223344, 0, 1'b0, "nonsec");
      do_xfer(1'b0, 12'h020, 3'd3, 1'b0, 1'b0, 32'h0, 32'h11223344, 0, 1'b0, "oversize");
      do_xfer(1'b0, 12'h024, 3'd2, 1'b1, 1'b0, 32'hCAFEF00D, 32'h0, 0, 1'b1, "slave_err");
      do_xfer(1'b0, 12'h028, 3'd2, 1'b1, 1'b0, 32'h01020304, 32'h0, 10, 1'b0, "timeout");
      do_xfer(1'b0, 12'h013, 3'd0, 1'b0, 1'b0, 32'h0, 32'h99AABBCC, 2, 1'b0, "byte_read");
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      sel = 1'b0; hsel = 1'b1; htrans = 2'b10; haddr = 12'h020; hsize = 3'd2;
      hwrite = 1'b0; hnonsec = 1'b0;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00; rif_ready = 1'b0; rif_rdata = 32'h12345678;
      repeat (2) @(posedge clk);
      #2;
      n_checks++;
      if (rd_req !== 1'b1 || hreadyout !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_access: got rd=%0b rdy=%0b expected 1 0", rd_req, hreadyout);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0 || wr_req !== 1'b0 ||
          rd_req !== 1'b0 || raddr !== 12'h0 || rstrb !== 4'h0 || rwdata !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset: got rdy=%0b resp=%0b rdata=%h wr=%0b rd=%0b addr=%h strb=%b wdata=%h expected 1 0 0 0 0 0 0 0",
                  hreadyout, hresp, hrdata, wr_req, rd_req, raddr, rstrb, rwdata);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (hreadyout !== 1'b1 || rd_req !== 1'b0) begin
         n_fail++;
         $display("FAIL after_reset: got rdy=%0b rd=%0b expected 1 0", hreadyout, rd_req);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] wd, rd;
      wd = $urandom;
      rd = $urandom;
      @(posedge clk); #1;
      sel = 1'b0; rif_ready = 1'b1; rif_err = 1'b0; rif_rdata = rd;
      hsel = 1'b1; htrans = 2'b10; haddr = 12'h104; hsize = 3'd2; hwrite = 1'b1; hnonsec = 1'b0;
      @(posedge clk); #1;
      haddr = 12'h208; hwrite = 1'b0; hwdata = wd;
      @(negedge clk);
      n_checks++;
      if (wr_req !== 1'b1 || raddr !== 12'h104 || hreadyout !== 1'b1 || rwdata !== wd) begin
         n_fail++;
         $display("FAIL b2b_write: got wr=%0b addr=%h rdy=%0b wdata=%h expected 1 104 1 %h",
                  wr_req, raddr, hreadyout, rwdata, wd);
      end
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00;
      @(negedge clk);
      n_checks++;
      if (rd_req !== 1'b1 || raddr !== 12'h208 || hreadyout !== 1'b1 || hrdata !== rd) begin
         n_fail++;
         $display("FAIL b2b_read: got rd=%0b addr=%h rdy=%0b rdata=%h expected 1 208 1 %h",
                  rd_req, raddr, hreadyout, hrdata, rd);
      end
      @(posedge clk); #1;
      rif_ready = 1'b0;
   endtask

   task automatic test_random();
      int          nb, ai, waits;
      logic [2:0]  sz;
      for (int d = 0; d < 2; d++) begin
         for (int n = 0; n < 30; n++) begin
            sz = 3'($urandom_range(0, 3));
            nb = 1 << sz;
            ai = int'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) ai = ai - (ai % nb);
            waits = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
            do_xfer(d[0], 12'(ai), sz, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) == 0), $urandom, $urandom, waits,
                    1'($urandom_range(0, 7) == 0), "random");
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; sel = 1'b0; haddr = '0; hsel = 1'b0; hnonsec = 1'b0; hwrite = 1'b0;
      hsize = '0; hburst = '0; htrans = '0; hwdata = '0; rif_rdata = '0;
      rif_ready = 1'b0; rif_err = 1'b0;
      test_reset();
      test_idle_busy();
      test_directed();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
